// File: rtl/mem_access_unit.sv
// Memory-stage data-memory initiator: formats load/store requests, extends load data, registers WB fields.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses retire as traps instead of issuing.
module mem_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_opr_res,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_rd_en,
  input  logic            ex_wr_en,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_pc4,
  input  logic            ex_rf_en,
  input  logic [1:0]      ex_wb_sel,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_opr_res,
  output logic [XLEN-1:0] wb_dmem_rdata,
  output logic [XLEN-1:0] wb_lsu_rdata,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_pc4,
  output logic            wb_rf_en,
  output logic [1:0]      wb_wb_sel,
  output logic            wb_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              store_q, store_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   opr_q, opr_d;
  logic              rf_en_q, rf_en_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic              req_valid_q, req_valid_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [3:0]        req_be_q, req_be_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_opr_res_q, wb_opr_res_d;
  logic [XLEN-1:0]   wb_dmem_rdata_q, wb_dmem_rdata_d;
  logic [XLEN-1:0]   wb_lsu_rdata_q, wb_lsu_rdata_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_pc4_q, wb_pc4_d;
  logic              wb_rf_en_q, wb_rf_en_d;
  logic [1:0]        wb_wb_sel_q, wb_wb_sel_d;
  logic              wb_misalign_q, wb_misalign_d;

  logic              is_mem;
  logic              misaligned;
  logic              mis_trap;
  logic [1:0]        ex_off;

  // Size 2'b11 falls into the word cases via size[1].
  function automatic logic [1:0] align_off(input logic [1:0] addr_lo, input logic [1:0] size);
    if (size[1])              return 2'b00;
    else if (size == 2'b01)   return {addr_lo[1], 1'b0};
    else                      return addr_lo;
  endfunction

  function automatic logic [3:0] fmt_be(input logic [1:0] off, input logic [1:0] size);
    if (size[1])              return 4'b1111;
    else if (size == 2'b01)   return 4'b0011 << off;
    else                      return 4'b0001 << off;
  endfunction

  function automatic logic [XLEN-1:0] fmt_wdata(input logic [XLEN-1:0] wd, input logic [1:0] size);
    if (size[1])              return wd;
    else if (size == 2'b01)   return {2{wd[15:0]}};
    else                      return {4{wd[7:0]}};
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata, input logic [1:0] off,
                                                  input logic [1:0] size, input logic uns);
    logic [XLEN-1:0]    sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    if (size[1])              return sh;
    else if (size == 2'b01)   return uns ? {16'h0, sh[15:0]} : XLEN'(h);
    else                      return uns ? {24'h0, sh[7:0]}  : XLEN'(b);
  endfunction

  assign is_mem     = ex_rd_en | ex_wr_en;
  assign ex_off     = align_off(ex_addr[1:0], ex_size);
  assign misaligned = (ex_size == 2'b01 && ex_addr[0]) || (ex_size[1] && ex_addr[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
  assign mis_trap   = is_mem & misaligned;
`else
  assign mis_trap   = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    size_d          = size_q;
    uns_d           = uns_q;
    store_d         = store_q;
    rd_d            = rd_q;
    pc4_d           = pc4_q;
    opr_d           = opr_q;
    rf_en_d         = rf_en_q;
    wb_sel_d        = wb_sel_q;
    req_valid_d     = req_valid_q;
    req_addr_d      = req_addr_q;
    req_we_d        = req_we_q;
    req_be_d        = req_be_q;
    req_wdata_d     = req_wdata_q;
    wb_valid_d      = 1'b0;
    wb_opr_res_d    = wb_opr_res_q;
    wb_dmem_rdata_d = wb_dmem_rdata_q;
    wb_lsu_rdata_d  = wb_lsu_rdata_q;
    wb_rd_d         = wb_rd_q;
    wb_pc4_d        = wb_pc4_q;
    wb_rf_en_d      = wb_rf_en_q;
    wb_wb_sel_d     = wb_wb_sel_q;
    wb_misalign_d   = wb_misalign_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (!is_mem || mis_trap) begin
            // Pass-through and misalignment traps both retire directly from IDLE.
            wb_valid_d      = 1'b1;
            wb_opr_res_d    = ex_opr_res;
            wb_dmem_rdata_d = '0;
            wb_lsu_rdata_d  = '0;
            wb_rd_d         = ex_rd;
            wb_pc4_d        = ex_pc4;
            wb_rf_en_d      = ex_rf_en & ~mis_trap;
            wb_wb_sel_d     = ex_wb_sel;
            wb_misalign_d   = mis_trap;
          end else begin
            state_d     = S_REQ;
            off_d       = ex_off;
            size_d      = ex_size;
            uns_d       = ex_unsigned;
            store_d     = ex_wr_en;
            rd_d        = ex_rd;
            pc4_d       = ex_pc4;
            opr_d       = ex_opr_res;
            rf_en_d     = ex_rf_en;
            wb_sel_d    = ex_wb_sel;
            req_valid_d = 1'b1;
            req_addr_d  = {ex_addr[XLEN-1:2], 2'b00};
            req_we_d    = ex_wr_en;
            req_be_d    = fmt_be(ex_off, ex_size);
            req_wdata_d = fmt_wdata(ex_wdata, ex_size);
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          if (store_q) begin
            state_d         = S_IDLE;
            wb_valid_d      = 1'b1;
            wb_opr_res_d    = opr_q;
            wb_dmem_rdata_d = '0;
            wb_lsu_rdata_d  = '0;
            wb_rd_d         = rd_q;
            wb_pc4_d        = pc4_q;
            wb_rf_en_d      = 1'b0;
            wb_wb_sel_d     = wb_sel_q;
            wb_misalign_d   = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d         = S_IDLE;
          wb_valid_d      = 1'b1;
          wb_opr_res_d    = opr_q;
          wb_dmem_rdata_d = dmem_rdata;
          wb_lsu_rdata_d  = load_extend(dmem_rdata, off_q, size_q, uns_q);
          wb_rd_d         = rd_q;
          wb_pc4_d        = pc4_q;
          wb_rf_en_d      = rf_en_q;
          wb_wb_sel_d     = wb_sel_q;
          wb_misalign_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      off_q           <= '0;
      size_q          <= '0;
      uns_q           <= 1'b0;
      store_q         <= 1'b0;
      rd_q            <= '0;
      pc4_q           <= '0;
      opr_q           <= '0;
      rf_en_q         <= 1'b0;
      wb_sel_q        <= '0;
      req_valid_q     <= 1'b0;
      req_addr_q      <= '0;
      req_we_q        <= 1'b0;
      req_be_q        <= '0;
      req_wdata_q     <= '0;
      wb_valid_q      <= 1'b0;
      wb_opr_res_q    <= '0;
      wb_dmem_rdata_q <= '0;
      wb_lsu_rdata_q  <= '0;
      wb_rd_q         <= '0;
      wb_pc4_q        <= '0;
      wb_rf_en_q      <= 1'b0;
      wb_wb_sel_q     <= '0;
      wb_misalign_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      off_q           <= off_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      store_q         <= store_d;
      rd_q            <= rd_d;
      pc4_q           <= pc4_d;
      opr_q           <= opr_d;
      rf_en_q         <= rf_en_d;
      wb_sel_q        <= wb_sel_d;
      req_valid_q     <= req_valid_d;
      req_addr_q      <= req_addr_d;
      req_we_q        <= req_we_d;
      req_be_q        <= req_be_d;
      req_wdata_q     <= req_wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_opr_res_q    <= wb_opr_res_d;
      wb_dmem_rdata_q <= wb_dmem_rdata_d;
      wb_lsu_rdata_q  <= wb_lsu_rdata_d;
      wb_rd_q         <= wb_rd_d;
      wb_pc4_q        <= wb_pc4_d;
      wb_rf_en_q      <= wb_rf_en_d;
      wb_wb_sel_q     <= wb_wb_sel_d;
      wb_misalign_q   <= wb_misalign_d;
    end
  end

  assign ex_ready       = (state_q == S_IDLE) && !rst;
  assign dmem_req_valid = req_valid_q;
  assign dmem_addr      = req_addr_q;
  assign dmem_we        = req_we_q;
  assign dmem_be        = req_be_q;
  assign dmem_wdata     = req_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_opr_res     = wb_opr_res_q;
  assign wb_dmem_rdata  = wb_dmem_rdata_q;
  assign wb_lsu_rdata   = wb_lsu_rdata_q;
  assign wb_rd          = wb_rd_q;
  assign wb_pc4         = wb_pc4_q;
  assign wb_rf_en       = wb_rf_en_q;
  assign wb_wb_sel      = wb_wb_sel_q;
  assign wb_misalign    = wb_misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store transactions plus hand-written corner sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_addr, ex_opr_res, ex_wdata, ex_pc4;
  logic        ex_rd_en, ex_wr_en, ex_unsigned, ex_rf_en;
  logic [1:0]  ex_size, ex_wb_sel;
  logic [4:0]  ex_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_rf_en, wb_misalign;
  logic [31:0] wb_opr_res, wb_dmem_rdata, wb_lsu_rdata, wb_pc4;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_wb_sel;

  int n_total = 0;
  int n_pass  = 0;

  mem_access_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_addr(ex_addr), .ex_opr_res(ex_opr_res), .ex_wdata(ex_wdata),
    .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_rd(ex_rd), .ex_pc4(ex_pc4), .ex_rf_en(ex_rf_en), .ex_wb_sel(ex_wb_sel),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_opr_res(wb_opr_res), .wb_dmem_rdata(wb_dmem_rdata),
    .wb_lsu_rdata(wb_lsu_rdata), .wb_rd(wb_rd), .wb_pc4(wb_pc4), .wb_rf_en(wb_rf_en),
    .wb_wb_sel(wb_wb_sel), .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_lsu;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic rd_en, input logic wr_en, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_rd_en    = rd_en;
    ex_wr_en    = wr_en;
    ex_size     = size;
    ex_unsigned = uns;
    ex_addr     = addr;
    ex_opr_res  = addr;
    ex_wdata    = wdata;
    ex_rd       = rd;
    ex_pc4      = addr + 32'h4;
    ex_rf_en    = 1'b1;
    ex_wb_sel   = 2'b01;
  endtask

  task automatic do_mem(input vec_t v, input logic [4:0] rd);
    logic is_store;
    is_store = v.wr_en;
    chk("ex_ready_before", ex_ready, 1);
    drive_ex(v.rd_en, v.wr_en, v.size, v.uns, v.addr, v.wdata, rd);
    tick();
    ex_valid = 1'b0;
    chk("req_valid", dmem_req_valid, 1);
    chk("wb_valid_after_accept", wb_valid, 0);
    for (int i = 0; i < v.delay; i++) begin
      chk("ex_ready_busy", ex_ready, 0);
      tick();
    end
    chk("req_valid_held", dmem_req_valid, 1);
    chk("dmem_addr", dmem_addr, v.exp_addr);
    chk("dmem_be", dmem_be, v.exp_be);
    chk("dmem_we", dmem_we, is_store);
    if (is_store) chk("dmem_wdata", dmem_wdata, v.exp_wdata);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("req_valid_dropped", dmem_req_valid, 0);
    if (is_store) begin
      chk("st_wb_valid", wb_valid, 1);
      chk("st_wb_rf_en", wb_rf_en, 0);
      chk("st_ex_ready", ex_ready, 1);
      chk("st_wb_opr_res", wb_opr_res, v.addr);
    end else begin
      chk("ld_wait_wb_valid", wb_valid, 0);
      chk("ld_wait_ex_ready", ex_ready, 0);
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = v.rdata;
      tick();
      dmem_rsp_valid = 1'b0;
      chk("ld_wb_valid", wb_valid, 1);
      chk("ld_lsu_rdata", wb_lsu_rdata, v.exp_lsu);
      chk("ld_dmem_rdata", wb_dmem_rdata, v.rdata);
      chk("ld_wb_rf_en", wb_rf_en, 1);
      chk("ld_wb_rd", wb_rd, rd);
      chk("ld_wb_pc4", wb_pc4, v.addr + 32'h4);
      chk("ld_ex_ready", ex_ready, 1);
      chk("ld_wb_misalign", wb_misalign, 0);
    end
    tick();
    chk("wb_valid_pulse", wb_valid, 0);
  endtask

  initial begin
    //              rd wr size uns addr          wdata         rdata         dly exp_addr      be       exp_wdata     exp_lsu
    vecs[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80AB_CDEF, 2, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_BEEF, 32'h0,        0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_0000, 0, 32'h0000_2000, 4'b1100, 32'h0,        32'h0000_8001};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0,        32'h1234_F00D, 1, 32'h0000_2000, 4'b0011, 32'h0,        32'hFFFF_F00D};
    vecs[4] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_4000, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_5001, 32'h0,        32'h1122_8344, 0, 32'h0000_5000, 4'b0010, 32'h0,        32'h0000_0083};
    vecs[6] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'hAABB_CC5A, 32'h0,        1, 32'h0000_6000, 4'b0010, 32'h5A5A_5A5A, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hCAFE_F00D, 32'h0,        0, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_8000, 32'h0,        32'h8765_4321, 0, 32'h0000_8000, 4'b1111, 32'h0,        32'h8765_4321};

    rst            = 1'b1;
    ex_valid       = 1'b0;
    ex_addr        = '0; ex_opr_res = '0; ex_wdata = '0; ex_pc4 = '0;
    ex_rd_en       = 1'b0; ex_wr_en = 1'b0; ex_unsigned = 1'b0; ex_rf_en = 1'b0;
    ex_size        = 2'b00; ex_wb_sel = 2'b00; ex_rd = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = '0;
    #1;
    chk("rst_ex_ready", ex_ready, 0);
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_opr_res", wb_opr_res, 0);
    chk("rst_dmem_be", dmem_be, 0);
    chk("rst_wb_misalign", wb_misalign, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ex_ready", ex_ready, 1);

    for (int i = 0; i < 9; i++) do_mem(vecs[i], 5'(i + 1));

    // Back-to-back ALU ops: one retirement per cycle, load fields cleared.
    for (int i = 0; i < 4; i++) begin
      drive_ex(1'b0, 1'b0, 2'b10, 1'b0, 32'(i + 1), 32'h0, 5'(i + 10));
      tick();
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_wb_opr_res", wb_opr_res, 32'(i + 1));
      chk("alu_wb_rd", wb_rd, 32'(i + 10));
      chk("alu_lsu_rdata", wb_lsu_rdata, 0);
    end
    ex_valid = 1'b0;
    tick();
    chk("alu_pulse_end", wb_valid, 0);

`ifdef MISALIGN_TRAP_EN
    drive_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd7);
    tick();
    ex_valid = 1'b0;
    chk("mis_req_valid", dmem_req_valid, 0);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_misalign", wb_misalign, 1);
    chk("mis_wb_rf_en", wb_rf_en, 0);
    chk("mis_ex_ready", ex_ready, 1);
    tick();
    chk("mis_pulse_end", wb_valid, 0);
`else
    begin
      vec_t mv;
      mv = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0102_0304, 0,
             32'h0000_3000, 4'b1111, 32'h0, 32'h0102_0304};
      do_mem(mv, 5'd7);
    end
`endif

    // Reset while waiting for a load response that is presented at the same time.
    drive_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'h0, 5'd3);
    tick();
    ex_valid       = 1'b0;
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("rstw_in_wait", ex_ready, 0);
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'h5555_AAAA;
    rst            = 1'b1;
    #1;
    chk("rstw_req_valid", dmem_req_valid, 0);
    chk("rstw_ex_ready_in_rst", ex_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstw_wb_valid", wb_valid, 0);
    chk("rstw_ex_ready", ex_ready, 1);
    chk("rstw_req_idle", dmem_req_valid, 0);
    dmem_rsp_valid = 1'b0;
    tick();
    chk("rstw_wb_valid_late", wb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
